cam_rgb_capture: RTL

Write-side capture stage of the pixel pipeline: samples a DVP-style camera byte bus (VSYNC/HREF/8-bit data, RGB565, two bytes per pixel) on wclk, expands each pixel to RGB888 and pushes it into the write port of the downstream clock-crossing RGB FIFO. It owns frame alignment, FIFO backpressure handling (whole-frame drop on overflow) and per-frame status counters for the control plane.

---
 rtl/cam_rgb_capture.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cam_rgb_capture.sv
// cam_rgb_capture
// Write-side capture of a DVP camera byte stream (RGB565, two bytes per pixel,
// high byte first). Each pixel is expanded to RGB888 and pushed into the write
// port of the clock-crossing RGB FIFO. When the FIFO is full, the rest of that
// frame is dropped. Complete and aborted frames are counted.
//
// Ports
//   wclk         pixel/write clock (camera PCLK)
//   wrst         asynchronous active-high reset
//   cam_vsync    frame blanking, active high
//   cam_href     line valid, active high
//   cam_d        camera byte
//   fifo_w_full  FIFO full flag, write domain
//   fifo_w_en    one-cycle write strobe per pixel
//   fifo_w_data  {R8,G8,B8}
//   ovf_clr      clears ovf_sticky and line_err (a set in the same cycle wins)
//   ovf_sticky   a pixel was lost to a full FIFO
//   line_err     HREF fell while half a pixel was held
//   frame_cnt    frames delivered complete (wraps)
//   drop_cnt     frames aborted by overflow (wraps)
//
// state   | meaning
// --------+--------------------------------------------------------------
// WAIT_VS | after reset; ignore data until the first VSYNC falling edge
// ACTIVE  | capture pixels; a VSYNC rising edge closes a complete frame
// DROP    | frame aborted by overflow; discard until the VSYNC rising edge

module cam_rgb_capture #(
   parameter int CNT_BITS = 16
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                cam_vsync,
   input  logic                cam_href,
   input  logic [7:0]          cam_d,
   input  logic                fifo_w_full,
   output logic                fifo_w_en,
   output logic [23:0]         fifo_w_data,
   input  logic                ovf_clr,
   output logic                ovf_sticky,
   output logic                line_err,
   output logic [CNT_BITS-1:0] frame_cnt,
   output logic [CNT_BITS-1:0] drop_cnt
);

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      ACTIVE  = 2'd1,
      DROP    = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_vs_q;
   logic        r_vs_qq;
   logic        r_hr_q;
   logic [7:0]  r_d_q;
   logic        r_phase;
   logic [7:0]  r_hi;

   logic        w_vs_rise;
   logic        w_vs_fall;
   logic        w_byte_ok;
   logic        w_pix_vld;
   logic        w_pix_wr;
   logic        w_pix_ovf;
   logic        w_line_err;
   logic        w_frame_inc;
   logic        w_drop_inc;
   logic [15:0] w_pix565;
   logic [23:0] w_rgb888;

   // Input stage: everything downstream uses only these registered copies.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_vs_q  <= 1'b0;
         r_vs_qq <= 1'b0;
         r_hr_q  <= 1'b0;
         r_d_q   <= 8'h00;
      end else begin
         r_vs_q  <= cam_vsync;
         r_vs_qq <= r_vs_q;
         r_hr_q  <= cam_href;
         r_d_q   <= cam_d;
      end
   end

   assign w_vs_rise = r_vs_q & ~r_vs_qq;
   assign w_vs_fall = ~r_vs_q & r_vs_qq;

   // VSYNC overrides HREF, so no byte is accepted during blanking.
   assign w_byte_ok = (r_state == ACTIVE) & r_hr_q & ~r_vs_q;
   assign w_pix_vld = w_byte_ok & r_phase;
   assign w_pix_wr  = w_pix_vld & ~fifo_w_full;
   assign w_pix_ovf = w_pix_vld & fifo_w_full;

   // The phase can only be 1 if the previous cycle accepted a high byte. If
   // HREF is now low, the line ended with half a pixel held.
   assign w_line_err = r_phase & ~r_hr_q;

   assign w_pix565 = {r_hi, r_d_q};
   assign w_rgb888 = {w_pix565[15:11], w_pix565[15:13],
                      w_pix565[10:5],  w_pix565[10:9],
                      w_pix565[4:0],   w_pix565[4:2]};

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_state <= WAIT_VS;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_frame_inc = 1'b0;
      w_drop_inc  = 1'b0;
      case (r_state)
         WAIT_VS: begin
            if (w_vs_fall) w_state_nxt = ACTIVE;
         end
         ACTIVE: begin
            // A pixel needs vs_q=0 and a rising edge needs vs_q=1, so these
            // two branches never fire in the same cycle.
            if (w_pix_ovf) begin
               w_state_nxt = DROP;
            end else if (w_vs_rise) begin
               w_frame_inc = 1'b1;
            end
         end
         DROP: begin
            if (w_vs_rise) begin
               w_drop_inc  = 1'b1;
               w_state_nxt = ACTIVE;
            end
         end
         default: w_state_nxt = WAIT_VS;
      endcase
   end

   // The phase returns to 0 whenever no byte is accepted. This covers the
   // HREF falling edge, VSYNC high, and the non-capturing states.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_phase <= 1'b0;
         r_hi    <= 8'h00;
      end else begin
         r_phase <= w_byte_ok ? ~r_phase : 1'b0;
         if (w_byte_ok && !r_phase) r_hi <= r_d_q;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         fifo_w_en   <= 1'b0;
         fifo_w_data <= 24'h000000;
      end else begin
         fifo_w_en <= w_pix_wr;
         if (w_pix_wr) fifo_w_data <= w_rgb888;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         ovf_sticky <= 1'b0;
         line_err   <= 1'b0;
      end else begin
         if (w_pix_ovf)    ovf_sticky <= 1'b1;
         else if (ovf_clr) ovf_sticky <= 1'b0;
         if (w_line_err)   line_err <= 1'b1;
         else if (ovf_clr) line_err <= 1'b0;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (w_frame_inc) frame_cnt <= frame_cnt + 1'b1;
         if (w_drop_inc)  drop_cnt  <= drop_cnt + 1'b1;
      end
   end

endmodule
